pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline stage register. It is the successor to the fixed-field inter-stage registers, and any ID/EX, EX/MEM or MEM/WB boundary can instantiate it.
- Payload is carried as two flat buses: control (CTRL_W) and data (DATA_W).
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure never needs a combinational ready path.
- Flush squashes in-flight entries and zeroes a parameter-selected set of control bits, producing a bubble.

Parameters:
CTRL_W, 16, width of control payload (reg_write, mem_write, branch, ...)
DATA_W, 128, width of data payload (pc_4, operands, immediates, register indices)
FLUSH_MASK, {CTRL_W{1'b1}}, bit=1 means the control bit is cleared in the output register on flush
STAT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
i_flush  input  1  squash all held entries this cycle
i_valid  input  1  upstream has a payload
o_ready  output  1  stage can accept (= skid entry empty)
i_ctrl  input  CTRL_W  upstream control payload
i_data  input  DATA_W  upstream data payload
o_valid  output  1  output register holds a live entry
i_ready  input  1  downstream accepts this cycle
o_ctrl  output  CTRL_W  registered control payload
o_data  output  DATA_W  registered data payload
o_occupancy  output  2  entries held: 0, 1 or 2
o_stall_cnt  output  STAT_W  cycles with o_valid && !i_ready (optional feature)
o_squash_cnt  output  STAT_W  valid entries killed by flush (optional feature)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. Reset has priority over every other input.
- Storage and outputs:
  - Main register M drives o_ctrl/o_data/o_valid.
  - Skid register S is internal.
  - All outputs are registered, except o_ready = !S_valid, which is a flop output with no path from i_ready.
- Reset values: o_valid=0, o_ctrl=0, o_data=0, o_occupancy=0, S cleared, o_ready=1 from the first cycle after reset, counters=0.
- Definitions: accept = i_valid && o_ready; drain = o_valid && i_ready.
- States, encoded as occupancy:
  - EMPTY(0):
    - accept -> FULL, M<=in.
    - Else hold.
  - FULL(1):
    - accept&&drain -> FULL, M<=in.
    - accept&&!drain -> SKID, S<=in.
    - !accept&&drain -> EMPTY.
    - Neither -> hold.
  - SKID(2):
    - o_ready=0, so input is never accepted.
    - drain -> FULL, M<=S.
    - Else hold.
- Latency: 1 cycle from accept to o_valid when the stage is empty. Full throughput of 1 entry/cycle while i_ready stays high.
- Ordering: strict FIFO. An entry in S always leaves after M.
- Payload hold: when the stage goes EMPTY by drain, o_ctrl/o_data keep their last values. Consumers must qualify with o_valid.
- Flush (i_flush=1, no reset):
  - Next state is EMPTY and S is invalidated.
  - o_ctrl <= o_ctrl & ~FLUSH_MASK.
  - o_data is unchanged.
  - The input offered in the same cycle is dropped, even if o_ready=1.
  - Flush overrides simultaneous accept and drain. Downstream must not count a drain in the flush cycle as squashed; it was already taken.
- Back-to-back flush keeps the stage EMPTY. The masked bits stay 0 until the next load.

Optional Feature:
Macro PIPE_SKID_REG_STATS_EN.
- Defined:
  - o_stall_cnt increments each cycle o_valid && !i_ready && !i_flush.
  - o_squash_cnt adds occupancy (0/1/2) on each flush cycle.
  - Both counters saturate at all-ones, never wrap, and are cleared by reset.
- Undefined: both ports remain present, tied to 0, with no counter logic.

Test Plan:
- Reset then stream: i_valid=1, i_ready=1, i_ctrl=0x0001..0x0005 on consecutive cycles -> o_valid rises 1 cycle later; o_ctrl sequence 0x0001..0x0005 with no gaps; o_occupancy stays 1; o_ready stays 1.
- Backpressure: M holds 0x00A1, i_ready=0, offer 0x00A2 then 0x00A3 -> 0x00A2 accepted into S, occupancy=2, o_ready=0, 0x00A3 is held upstream. Then raise i_ready -> outputs are 0x00A1, 0x00A2, 0x00A3 in order.
- Flush in SKID, FLUSH_MASK=0x000F, o_ctrl=0x12FF, i_valid=1 same cycle -> next cycle o_valid=0, occupancy=0, o_ctrl=0x12F0, o_data unchanged, offered input absent.
- Flush with simultaneous drain in FULL -> entry consumed exactly once; next cycle EMPTY; a new accept 1 cycle later appears normally.
- Mid-operation reset in SKID state -> next cycle all outputs 0, o_ready=1. A reset asserted together with i_flush and i_valid yields the same result.
- With PIPE_SKID_REG_STATS_EN, STAT_W=4: hold i_ready=0 for 20 cycles with o_valid=1 -> o_stall_cnt=15 (saturated). Flush at occupancy 2 -> o_squash_cnt=2.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: main register M plus one skid entry S, so ready never depends on i_ready.
// Optional statistics counters are enabled with the PIPE_SKID_REG_STATS_EN macro.
module pipe_skid_reg #(
    parameter int                CTRL_W     = 16,
    parameter int                DATA_W     = 128,
    parameter logic [CTRL_W-1:0] FLUSH_MASK = {CTRL_W{1'b1}},
    parameter int                STAT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occupancy,
    output logic [STAT_W-1:0] o_stall_cnt,
    output logic [STAT_W-1:0] o_squash_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
    logic                accept, drain;

    assign accept = i_valid && ready_q;
    assign drain  = valid_q && i_ready;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (i_flush) begin
            // Flush wins over accept/drain; data is left as-is, only masked control bits clear.
            state_d  = EMPTY;
            m_ctrl_d = m_ctrl_q & ~FLUSH_MASK;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    state_d  = FULL;
                    m_ctrl_d = i_ctrl;
                    m_data_d = i_data;
                end
                FULL: begin
                    if (accept && drain) begin
                        m_ctrl_d = i_ctrl;
                        m_data_d = i_data;
                    end else if (accept) begin
                        state_d  = SKID;
                        s_ctrl_d = i_ctrl;
                        s_data_d = i_data;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                SKID: if (drain) begin
                    state_d  = FULL;
                    m_ctrl_d = s_ctrl_q;
                    m_data_d = s_data_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != SKID);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            m_ctrl_q <= '0;
            m_data_q <= '0;
            s_ctrl_q <= '0;
            s_data_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            m_ctrl_q <= m_ctrl_d;
            m_data_q <= m_data_d;
            s_ctrl_q <= s_ctrl_d;
            s_data_q <= s_data_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_ready     = ready_q;
    assign o_ctrl      = m_ctrl_q;
    assign o_data      = m_data_q;
    assign o_occupancy = state_q;

`ifdef PIPE_SKID_REG_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic [STAT_W:0]   squash_sum;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;
        squash_sum   = {1'b0, squash_cnt_q} + {{(STAT_W-1){1'b0}}, state_q};
        if (valid_q && !i_ready && !i_flush && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
        // Squash adds the entry count; the carry bit signals saturation.
        if (i_flush)
            squash_cnt_d = squash_sum[STAT_W] ? {STAT_W{1'b1}} : squash_sum[STAT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign o_stall_cnt  = stall_cnt_q;
    assign o_squash_cnt = squash_cnt_q;
`else
    assign o_stall_cnt  = '0;
    assign o_squash_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized + directed bench for pipe_skid_reg against a queue-based reference model.
module tb_pipe_skid_reg;
    localparam int          CTRL_W = 16;
    localparam int          DATA_W = 32;
    localparam int          STAT_W = 4;
    localparam logic [15:0] MASK   = 16'h000F;
    localparam int          SAT    = 15;

    logic              clk = 1'b0;
    logic              reset, i_flush, i_valid, i_ready;
    logic [CTRL_W-1:0] i_ctrl;
    logic [DATA_W-1:0] i_data;
    logic              o_ready, o_valid;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_occupancy;
    logic [STAT_W-1:0] o_stall_cnt, o_squash_cnt;

    pipe_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_MASK(MASK), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_ctrl(o_ctrl), .o_data(o_data), .o_occupancy(o_occupancy),
        .o_stall_cnt(o_stall_cnt), .o_squash_cnt(o_squash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    int                stall_m, squash_m;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_stat(input int v);
`ifdef PIPE_SKID_REG_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Compare outputs to the model at negedge, then advance the model across the next posedge.
    task automatic step();
        bit acc, drn;
        @(negedge clk);
        chk("valid",  64'(o_valid),      64'(q.size() > 0));
        chk("ready",  64'(o_ready),      64'(q.size() < 2));
        chk("occ",    64'(o_occupancy),  64'(q.size()));
        chk("ctrl",   64'(o_ctrl),       64'(m_ctrl));
        chk("data",   64'(o_data),       64'(m_data));
        chk("stall",  64'(o_stall_cnt),  64'(exp_stat(stall_m)));
        chk("squash", 64'(o_squash_cnt), 64'(exp_stat(squash_m)));
        if (reset) begin
            q.delete();
            m_ctrl = '0; m_data = '0; stall_m = 0; squash_m = 0;
        end else if (i_flush) begin
            squash_m = (squash_m + q.size() > SAT) ? SAT : squash_m + q.size();
            q.delete();
            m_ctrl = m_ctrl & ~MASK;
        end else begin
            acc = i_valid && (q.size() < 2);
            drn = (q.size() > 0) && i_ready;
            if (q.size() > 0 && !i_ready && stall_m < SAT) stall_m++;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{c: i_ctrl, d: i_data});
            if (q.size() > 0) begin
                m_ctrl = q[0].c;
                m_data = q[0].d;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit rst, input bit fl, input bit v, input logic [15:0] c,
                       input logic [31:0] d, input bit rdy);
        reset = rst; i_flush = fl; i_valid = v; i_ctrl = c; i_data = d; i_ready = rdy;
        step();
    endtask

    initial begin
        logic [31:0] d12;
        reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_ctrl = '0; i_data = '0;
        q.delete(); m_ctrl = '0; m_data = '0; stall_m = 0; squash_m = 0;
        repeat (2) @(posedge clk);
        #1;
        drv(1, 0, 0, 16'h0, 32'h0, 0);

        // Streaming at full throughput
        for (int k = 1; k <= 5; k++) begin
            drv(0, 0, 1, 16'(k), $urandom, 1);
            chk("stream_ctrl", 64'(o_ctrl), 64'(k));
            chk("stream_occ",  64'(o_occupancy), 64'd1);
        end
        drv(0, 0, 0, 16'h0, 32'h0, 1);
        drv(0, 0, 0, 16'h0, 32'h0, 1);

        // Backpressure into skid, then drain in order
        drv(0, 0, 1, 16'h00A1, $urandom, 0);
        drv(0, 0, 1, 16'h00A2, $urandom, 0);
        drv(0, 0, 1, 16'h00A3, $urandom, 0);
        chk("bp_occ",   64'(o_occupancy), 64'd2);
        chk("bp_ready", 64'(o_ready), 64'd0);
        chk("bp_ctrl",  64'(o_ctrl), 64'h00A1);
        drv(0, 0, 1, 16'h00A3, 32'h0, 1);
        chk("bp_ctrl2", 64'(o_ctrl), 64'h00A2);
        drv(0, 0, 1, 16'h00A3, 32'h0, 1);
        chk("bp_ctrl3", 64'(o_ctrl), 64'h00A3);
        drv(0, 0, 0, 16'h0, 32'h0, 1);

        // Flush while in SKID with an offered input
        d12 = $urandom;
        drv(0, 0, 1, 16'h12FF, d12, 0);
        drv(0, 0, 1, 16'h3333, $urandom, 0);
        drv(0, 1, 1, 16'h7777, $urandom, 0);
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_occ",   64'(o_occupancy), 64'd0);
        chk("fl_ctrl",  64'(o_ctrl), 64'h12F0);
        chk("fl_data",  64'(o_data), 64'(d12));
        drv(0, 1, 0, 16'h0, 32'h0, 1);
        chk("fl2_ctrl", 64'(o_ctrl), 64'h12F0);

        // Flush with simultaneous drain in FULL, then normal accept
        drv(0, 0, 1, 16'h0044, $urandom, 1);
        drv(0, 1, 1, 16'h0999, $urandom, 1);
        chk("fd_occ", 64'(o_occupancy), 64'd0);
        drv(0, 0, 1, 16'h0055, $urandom, 1);
        chk("fd_valid", 64'(o_valid), 64'd1);
        chk("fd_ctrl",  64'(o_ctrl), 64'h0055);
        drv(0, 0, 0, 16'h0, 32'h0, 1);

        // Reset in SKID, plain and combined with flush/valid
        for (int r = 0; r < 2; r++) begin
            drv(0, 0, 1, 16'hBEEF, $urandom, 0);
            drv(0, 0, 1, 16'hCAFE, $urandom, 0);
            drv(1, r[0], r[0], 16'h1111, $urandom, 0);
            chk("rst_valid", 64'(o_valid), 64'd0);
            chk("rst_ready", 64'(o_ready), 64'd1);
            chk("rst_ctrl",  64'(o_ctrl), 64'd0);
            chk("rst_data",  64'(o_data), 64'd0);
            chk("rst_occ",   64'(o_occupancy), 64'd0);
        end

        // Counter saturation
        drv(0, 0, 1, 16'h0101, $urandom, 0);
        for (int k = 0; k < 20; k++) drv(0, 0, 0, 16'h0, 32'h0, 0);
        chk("stall_sat", 64'(o_stall_cnt), 64'(exp_stat(15)));
        drv(0, 0, 1, 16'h0202, $urandom, 0);
        drv(0, 1, 0, 16'h0, 32'h0, 0);
        chk("squash2", 64'(o_squash_cnt), 64'(exp_stat(2)));

        // Random traffic
        for (int k = 0; k < 3000; k++)
            drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) < 7), 16'($urandom), $urandom,
                ($urandom_range(0, 9) < 6));
        drv(0, 0, 0, 16'h0, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
